// File: rtl/eq_session_ctrl.sv
// eq_session_ctrl: codec-init handshake, N-band EQ setting mode driven by key
// pulses, and streaming of the changed band gains to the coefficient loader.
module eq_session_ctrl #(
  parameter int NUM_BANDS    = 6,
  parameter int GAIN_W       = 5,
  parameter int GAIN_DEFAULT = 16,
  parameter int GAIN_MAX     = 31,
  parameter int TIMEOUT      = 1000000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_init_done,
  output logic                           o_init_start,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic                           i_up,
  input  logic                           i_down,
  input  logic                           i_next,
  output logic [$clog2(NUM_BANDS)-1:0]   o_band,
  output logic [NUM_BANDS*GAIN_W-1:0]    o_gain_bus,
  output logic                           o_apply_valid,
  input  logic                           i_apply_ready,
  output logic [$clog2(NUM_BANDS)-1:0]   o_apply_band,
  output logic [GAIN_W-1:0]              o_apply_gain,
  output logic [1:0]                     o_state
);

  localparam int BAND_W = $clog2(NUM_BANDS);
  localparam int CNT_W  = $clog2(TIMEOUT);

  localparam logic [GAIN_W-1:0] GAIN_MAX_C = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] GAIN_DEF_C = GAIN_W'(GAIN_DEFAULT);
  localparam logic [BAND_W-1:0] BAND_LAST  = BAND_W'(NUM_BANDS - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SETTING = 2'd2,
    ST_APPLY   = 2'd3
  } state_t;

  state_t                 state_reg;
  logic                   init_start_reg;
  logic [BAND_W-1:0]      band_reg;
  logic [NUM_BANDS-1:0]   dirty_reg;
  logic [CNT_W-1:0]       tmo_cnt_reg;
  logic                   apply_valid_reg;
  logic [BAND_W-1:0]      apply_band_reg;
  logic [GAIN_W-1:0]      apply_gain_reg;

  logic [GAIN_W-1:0]      gain_reg  [NUM_BANDS];
  logic [GAIN_W-1:0]      gain_next [NUM_BANDS];
  logic [NUM_BANDS-1:0]   gain_chg;

  // Index of the lowest set bit; callers guarantee the mask is nonzero.
  function automatic logic [BAND_W-1:0] lowest_set(input logic [NUM_BANDS-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = BAND_W'(i);
    end
  endfunction

  // Up and down together cancel; adjustments only exist in setting mode.
  logic adj_up;
  logic adj_dn;
  assign adj_up = (state_reg == ST_SETTING) && i_up && !i_down;
  assign adj_dn = (state_reg == ST_SETTING) && i_down && !i_up;

  logic key_act;
  assign key_act = i_up || i_down || i_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
      logic              sel;
      logic [GAIN_W-1:0] g_nx;
      logic              g_chg;

      assign sel = (band_reg == BAND_W'(gi));

      // Saturating adjustment of the selected band; flags a real value change.
      always_comb begin
        g_nx  = gain_reg[gi];
        g_chg = 1'b0;
        if (sel && adj_up && (gain_reg[gi] < GAIN_MAX_C)) begin
          g_nx  = gain_reg[gi] + GAIN_W'(1);
          g_chg = 1'b1;
        end else if (sel && adj_dn && (gain_reg[gi] != '0)) begin
          g_nx  = gain_reg[gi] - GAIN_W'(1);
          g_chg = 1'b1;
        end
      end

      assign gain_next[gi] = g_nx;
      assign gain_chg[gi]  = g_chg;
      assign o_gain_bus[gi*GAIN_W +: GAIN_W] = gain_reg[gi];

      // Gain register bank; frozen outside setting mode since g_nx == gain_reg there.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) gain_reg[gi] <= GAIN_DEF_C;
        else          gain_reg[gi] <= g_nx;
      end
    end
  endgenerate

  // Dirty mask including this cycle's adjustment, so an exit in the same
  // cycle sees the freshly changed band.
  logic [NUM_BANDS-1:0] dirty_upd;
  logic [BAND_W-1:0]    first_band;
  logic [GAIN_W-1:0]    first_gain;
  assign dirty_upd  = dirty_reg | gain_chg;
  assign first_band = lowest_set(dirty_upd);
  assign first_gain = gain_next[first_band];

  // Next word while already in APPLY (gains are frozen, so read the registers).
  logic [BAND_W-1:0]    pick_band;
  logic [GAIN_W-1:0]    pick_gain;
  logic [NUM_BANDS-1:0] apply_oh;
  logic [NUM_BANDS-1:0] dirty_after;
  assign pick_band   = lowest_set(dirty_reg);
  assign pick_gain   = gain_reg[pick_band];
  assign apply_oh    = NUM_BANDS'(1) << apply_band_reg;
  assign dirty_after = dirty_reg & ~apply_oh;

  logic [BAND_W-1:0] band_wrap;
  assign band_wrap = (band_reg == BAND_LAST) ? '0 : band_reg + BAND_W'(1);

  logic tmo_hit;
  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

  // Session FSM with all control outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= ST_INIT;
      init_start_reg  <= 1'b1;
      band_reg        <= '0;
      dirty_reg       <= '0;
      tmo_cnt_reg     <= '0;
      apply_valid_reg <= 1'b0;
      apply_band_reg  <= '0;
      apply_gain_reg  <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (i_init_done) begin
            state_reg      <= ST_IDLE;
            init_start_reg <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (i_start) begin
            state_reg   <= ST_SETTING;
            band_reg    <= '0;
            tmo_cnt_reg <= '0;
          end
        end
        ST_SETTING: begin
          dirty_reg   <= dirty_upd;
          tmo_cnt_reg <= key_act ? '0 : tmo_cnt_reg + CNT_W'(1);
          if (i_next) band_reg <= band_wrap;
          if (i_stop || tmo_hit) begin
            if (dirty_upd != '0) begin
              state_reg       <= ST_APPLY;
              apply_valid_reg <= 1'b1;
              apply_band_reg  <= first_band;
              apply_gain_reg  <= first_gain;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_APPLY: begin
          if (apply_valid_reg) begin
            // Accepted word: drop its dirty bit and leave a one-cycle gap.
            if (i_apply_ready) begin
              dirty_reg       <= dirty_after;
              apply_valid_reg <= 1'b0;
              if (dirty_after == '0) state_reg <= ST_IDLE;
            end
          end else begin
            apply_valid_reg <= 1'b1;
            apply_band_reg  <= pick_band;
            apply_gain_reg  <= pick_gain;
          end
        end
      endcase
    end
  end

  assign o_state       = state_reg;
  assign o_init_start  = init_start_reg;
  assign o_band        = band_reg;
  assign o_apply_valid = apply_valid_reg;
  assign o_apply_band  = apply_band_reg;
  assign o_apply_gain  = apply_gain_reg;

endmodule

// File: tb/tb_eq_session_ctrl.sv
// tb_eq_session_ctrl: directed scenarios plus randomized key traffic, checked
// every cycle against a queue-based behavioural model of the session.
module tb_eq_session_ctrl;

  localparam int NB   = 6;
  localparam int GW   = 5;
  localparam int GDEF = 16;
  localparam int GMAX = 31;
  localparam int TMO  = 8;
  localparam int BW   = $clog2(NB);

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_init_done = 1'b0;
  logic i_start = 1'b0;
  logic i_stop = 1'b0;
  logic i_up = 1'b0;
  logic i_down = 1'b0;
  logic i_next = 1'b0;
  logic i_apply_ready = 1'b0;
  logic              o_init_start;
  logic [BW-1:0]     o_band;
  logic [NB*GW-1:0]  o_gain_bus;
  logic              o_apply_valid;
  logic [BW-1:0]     o_apply_band;
  logic [GW-1:0]     o_apply_gain;
  logic [1:0]        o_state;

  eq_session_ctrl #(
    .NUM_BANDS(NB), .GAIN_W(GW), .GAIN_DEFAULT(GDEF), .GAIN_MAX(GMAX), .TIMEOUT(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init_done(i_init_done),
    .o_init_start(o_init_start), .i_start(i_start), .i_stop(i_stop),
    .i_up(i_up), .i_down(i_down), .i_next(i_next), .o_band(o_band),
    .o_gain_bus(o_gain_bus), .o_apply_valid(o_apply_valid),
    .i_apply_ready(i_apply_ready), .o_apply_band(o_apply_band),
    .o_apply_gain(o_apply_gain), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int band;
    int gain;
  } word_t;

  // Behavioural model: plain integers, and the apply phase as a word queue.
  int    m_state;
  int    m_band;
  int    m_idle;
  int    m_gain [NB];
  bit    m_dirty[NB];
  word_t m_q[$];
  bit    m_gap;
  int    m_last_band;
  int    m_last_gain;
  word_t got_q[$];

  logic [NB*GW-1:0] all_def;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_band = 0; m_idle = 0; m_gap = 1'b0;
    m_last_band = 0; m_last_gain = 0;
    for (int b = 0; b < NB; b++) begin
      m_gain[b] = GDEF;
      m_dirty[b] = 1'b0;
    end
    m_q.delete();
  endtask

  task automatic model_step();
    bit keyed;
    bit leave;
    int g;
    case (m_state)
      0: if (i_init_done) m_state = 1;
      1: if (i_start) begin m_state = 2; m_band = 0; m_idle = 0; end
      2: begin
        keyed = i_up || i_down || i_next;
        g = m_gain[m_band];
        if (i_up && !i_down && g < GMAX) g = g + 1;
        else if (i_down && !i_up && g > 0) g = g - 1;
        if (g != m_gain[m_band]) begin
          m_gain[m_band] = g;
          m_dirty[m_band] = 1'b1;
        end
        leave = i_stop || (m_idle == TMO - 1);
        m_idle = keyed ? 0 : m_idle + 1;
        if (i_next) m_band = (m_band + 1) % NB;
        if (leave) begin
          for (int b = 0; b < NB; b++) begin
            if (m_dirty[b]) begin
              m_q.push_back('{b, m_gain[b]});
              m_dirty[b] = 1'b0;
            end
          end
          if (m_q.size() > 0) begin
            m_state = 3; m_gap = 1'b0;
            m_last_band = m_q[0].band; m_last_gain = m_q[0].gain;
          end else begin
            m_state = 1;
          end
        end
      end
      default: begin
        if (m_gap) begin
          m_gap = 1'b0;
          m_last_band = m_q[0].band; m_last_gain = m_q[0].gain;
        end else if (i_apply_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_state = 1;
          else m_gap = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [NB*GW-1:0] e;
    for (int b = 0; b < NB; b++) e[b*GW +: GW] = GW'(m_gain[b]);
    chk("state", 64'(o_state), 64'(m_state));
    chk("init_start", 64'(o_init_start), 64'(m_state == 0));
    chk("band", 64'(o_band), 64'(m_band));
    chk("gain_bus", 64'(o_gain_bus), 64'(e));
    chk("apply_valid", 64'(o_apply_valid), 64'(m_state == 3 && !m_gap));
    chk("apply_band", 64'(o_apply_band), 64'(m_last_band));
    chk("apply_gain", 64'(o_apply_gain), 64'(m_last_gain));
  endtask

  task automatic cycle();
    logic          pv;
    logic [BW-1:0] pb;
    logic [GW-1:0] pg;
    pv = o_apply_valid; pb = o_apply_band; pg = o_apply_gain;
    @(posedge i_clk);
    if (pv && i_apply_ready) begin
      got_q.push_back('{int'(pb), int'(pg)});
      $display("apply word band %0d gain %0d", pb, pg);
    end
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic press(input bit up, input bit dn, input bit nx, input bit st, input bit sp);
    i_up = up; i_down = dn; i_next = nx; i_start = st; i_stop = sp;
    cycle();
    i_up = 1'b0; i_down = 1'b0; i_next = 1'b0; i_start = 1'b0; i_stop = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (o_state !== s && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 64'(o_state), 64'(s));
  endtask

  task automatic chk_word(input int idx, input int band, input int gain);
    chk("word_band", 64'(idx < got_q.size() ? got_q[idx].band : -1), 64'(band));
    chk("word_gain", 64'(idx < got_q.size() ? got_q[idx].gain : -1), 64'(gain));
  endtask

  initial begin
    for (int b = 0; b < NB; b++) all_def[b*GW +: GW] = GW'(GDEF);

    // Reset and codec init handshake
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs();
    chk("rst_gain_bus", 64'(o_gain_bus), 64'(all_def));
    i_rst_n = 1'b1;
    repeat (10) begin
      cycle();
      chk("init_start_hold", 64'(o_init_start), 64'd1);
    end
    i_init_done = 1'b1;
    cycle();
    chk("init_to_idle", 64'(o_state), 64'd1);
    chk("init_start_drop", 64'(o_init_start), 64'd0);

    // Basic adjust and two-word apply
    i_apply_ready = 1'b1;
    press(0, 0, 0, 1, 0);
    repeat (3) press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    repeat (2) press(0, 1, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    chk("band0_19", 64'(o_gain_bus[4:0]), 64'd19);
    chk("band1_14", 64'(o_gain_bus[9:5]), 64'd14);
    chk("enter_apply", 64'(o_state), 64'd3);
    wait_state(2'd1, 20, "apply_done");
    chk("word_count", 64'(got_q.size()), 64'd2);
    chk_word(0, 0, 19);
    chk_word(1, 1, 14);
    got_q.delete();

    // Saturation, cancel, band wrap
    press(0, 0, 0, 1, 0);
    repeat (20) press(1, 0, 0, 0, 0);
    chk("sat_high", 64'(o_gain_bus[4:0]), 64'd31);
    repeat (40) press(0, 1, 0, 0, 0);
    chk("sat_low", 64'(o_gain_bus[4:0]), 64'd0);
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    chk("band2_17", 64'(o_gain_bus[14:10]), 64'd17);
    press(1, 1, 0, 0, 0);
    chk("updown_cancel", 64'(o_gain_bus[14:10]), 64'd17);
    repeat (NB) press(0, 0, 1, 0, 0);
    chk("band_wrap", 64'(o_band), 64'd2);
    press(0, 0, 0, 0, 1);
    wait_state(2'd1, 20, "apply_done2");
    chk("word_count2", 64'(got_q.size()), 64'd2);
    chk_word(0, 0, 0);
    chk_word(1, 2, 17);
    got_q.delete();

    // Timeout without changes, then timeout with a change
    press(0, 0, 0, 1, 0);
    repeat (TMO - 1) begin
      cycle();
      chk("tmo_wait", 64'(o_state), 64'd2);
    end
    cycle();
    chk("tmo_idle", 64'(o_state), 64'd1);
    chk("tmo_no_apply", 64'(got_q.size()), 64'd0);
    i_apply_ready = 1'b0;
    press(0, 0, 0, 1, 0);
    press(1, 0, 0, 0, 0);
    wait_state(2'd3, 20, "tmo_apply");

    // Backpressure stability, then reset mid-transfer
    repeat (5) begin
      cycle();
      chk("hold_valid", 64'(o_apply_valid), 64'd1);
      chk("hold_band", 64'(o_apply_band), 64'd0);
      chk("hold_gain", 64'(o_apply_gain), 64'd1);
    end
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(o_apply_valid), 64'd0);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_gains", 64'(o_gain_bus), 64'(all_def));
    check_outputs();
    #2;
    i_rst_n = 1'b1;

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      i_init_done   = ($urandom_range(0, 3) == 0);
      i_start       = ($urandom_range(0, 7) == 0);
      i_stop        = ($urandom_range(0, 15) == 0);
      i_up          = ($urandom_range(0, 5) == 0);
      i_down        = ($urandom_range(0, 5) == 0);
      i_next        = ($urandom_range(0, 7) == 0);
      i_apply_ready = ($urandom_range(0, 1) == 1);
      cycle();
      if ($urandom_range(0, 399) == 0) begin
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        i_rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eq_session_ctrl.md
Name: eq_session_ctrl

Overview:
Parametrised control FSM for the audio front end. It runs the codec-init handshake after reset, then serves an N-band equaliser setting mode driven by debounced keys. Adjusted band gains are held in a register bank. On exit from setting mode, only the bands that changed are streamed to the coefficient loader over a valid/ready handshake. It replaces the fixed six-band setting state with a generic band count, saturating gain arithmetic, dirty tracking and an inactivity timeout.

Parameters:
NUM_BANDS, 6, number of EQ bands (>=2)
GAIN_W, 5, gain code width per band (unsigned)
GAIN_DEFAULT, 16, reset gain code of every band (<= GAIN_MAX)
GAIN_MAX, 31, saturation ceiling (<= 2^GAIN_W-1)
TIMEOUT, 1000000, idle cycles in setting mode before auto-exit (>=2)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_init_done  in  1  codec I2C init finished (level)
o_init_start  out  1  request codec I2C init
i_start  in  1  one-cycle pulse: enter setting mode
i_stop  in  1  one-cycle pulse: leave setting mode
i_up  in  1  one-cycle pulse: raise selected band gain
i_down  in  1  one-cycle pulse: lower selected band gain
i_next  in  1  one-cycle pulse: select next band
o_band  out  $clog2(NUM_BANDS)  selected band index
o_gain_bus  out  NUM_BANDS*GAIN_W  all gains; band k at [k*GAIN_W +: GAIN_W]
o_apply_valid  out  1  apply word valid
i_apply_ready  in  1  loader accepts apply word
o_apply_band  out  $clog2(NUM_BANDS)  band being applied
o_apply_gain  out  GAIN_W  gain being applied
o_state  out  2  0 INIT, 1 IDLE, 2 SETTING, 3 APPLY

Behaviour:
- Reset (async, i_rst_n=0) values: state INIT, o_init_start=1, o_band=0, every gain=GAIN_DEFAULT, dirty mask=0, timeout counter=0, o_apply_valid=0, o_apply_band=0, o_apply_gain=0.
- Reset mid-APPLY drops the pending transfer. Dirty bits are lost.
- All outputs are registered. A key pulse shows its effect on the outputs one cycle after the sampling edge.
- INIT: o_init_start held 1. On the first edge with i_init_done=1, go to IDLE and set o_init_start=0. Keys are ignored.
- IDLE: i_start goes to SETTING, with o_band=0 and the timeout counter cleared. All other keys are ignored.
- SETTING, i_up alone: gain[o_band] increments, saturating at GAIN_MAX.
- SETTING, i_down alone: gain[o_band] decrements, saturating at 0.
- SETTING, i_up and i_down in the same cycle: no change.
- SETTING, dirty marking: dirty[o_band] is set only if the gain value actually changed. Saturated presses leave the dirty bit untouched.
- SETTING, i_next: o_band advances and wraps from NUM_BANDS-1 to 0.
- SETTING, i_next together with i_up/i_down: the adjustment applies to the old band, then the band advances.
- SETTING, timeout counter: increments every cycle with no up/down/next pulse and clears on any such pulse. i_start is ignored.
- SETTING exit: on i_stop, or when the counter reaches TIMEOUT-1, go to APPLY if the dirty mask is nonzero, else to IDLE.
- SETTING, simultaneous exit: if i_stop coincides with up/down, the adjustment and its dirty bit are taken first, then the exit decision uses the updated mask.
- APPLY: o_apply_valid=1, with o_apply_band set to the lowest set dirty index and o_apply_gain set to that band's gain.
- APPLY handshake: band and gain stay stable while valid=1 and ready=0. On valid&&ready, that dirty bit clears.
- APPLY sequencing: the next dirty band is presented the following cycle, giving at most one word per two cycles. When the mask becomes 0, valid deasserts and the FSM returns to IDLE in the same cycle.
- APPLY: keys are ignored, and gains are frozen.
- o_gain_bus always reflects the live gain registers.

Test Plan:
- Reset, i_init_done held 0 for 10 cycles, then set to 1 -> o_init_start=1 throughout the 0 phase, then drops to 0, o_state goes 0 to 1, o_gain_bus shows every band at 16.
- IDLE: i_start; i_up x3 on band 0; i_next; i_down x2; i_stop with ready=1 -> band0=19, band1=14, o_state=3. Apply words appear as (band 0, gain 19) then (band 1, gain 14). o_state then returns to 1.
- Band 0: i_up x20 -> gain saturates at 31. Then i_down x40 -> gain saturates at 0, and no wrap occurs.
- Set band 2 to 17 (dirty). Then i_up+i_down in the same cycle -> no change. i_next pressed NUM_BANDS times -> o_band returns to its start value.
- TIMEOUT=8: enter SETTING with no keys -> after 8 cycles o_state returns to 1 with no apply. Second pass: one i_up, then no keys -> auto-exit to APPLY.
- Apply with ready held low for 5 cycles -> valid, band and gain stable throughout. Then assert i_rst_n=0 mid-transfer -> o_apply_valid=0 immediately, o_state=0, gains return to 16.
